// File: rtl/waveform_bank_sched.sv
// Ping-pong bank scheduler: host writes fill one waveform bank while playback
// drains the other at a divided rate, swapping on commit and end-of-bank.
module waveform_bank_sched #(
  parameter int unsigned WR_ADDR_W = 11,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_in_write,
  input  logic                 commit,
  input  logic                 play_en,
  input  logic [DIV_W-1:0]     rate_div,
  output logic [WR_ADDR_W-1:0] wr_addr,
  output logic                 wr_bank,
  output logic [WR_ADDR_W-2:0] rd_addr,
  output logic                 rd_bank,
  output logic                 pop,
  output logic                 swap,
  output logic                 underrun,
  output logic                 overrun,
  output logic [1:0]           state
);

  localparam int unsigned RD_ADDR_W = WR_ADDR_W - 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StStall = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           full_q, full_d;
  logic [WR_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [RD_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic                 pop_q, pop_d;
  logic                 swap_q, swap_d;
  logic                 underrun_q, underrun_d;
  logic                 overrun_q, overrun_d;

  logic wr_full, rd_full, other_full;
  logic wr_ok, commit_ok;
  logic end_of_bank, cnt_hit;

  // All bank decisions use start-of-cycle occupancy.
  assign wr_full     = full_q[wr_bank_q];
  assign rd_full     = full_q[rd_bank_q];
  assign other_full  = full_q[~rd_bank_q];
  assign wr_ok       = pipe_in_write & ~wr_full;
  assign commit_ok   = commit & ~wr_full;
  assign end_of_bank = pop_q & (&rd_addr_q);
  assign cnt_hit     = (cnt_q == rate_div);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      full_q     <= 2'b00;
      wr_addr_q  <= '0;
      wr_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_bank_q  <= 1'b0;
      cnt_q      <= '0;
      pop_q      <= 1'b0;
      swap_q     <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_addr_q  <= wr_addr_d;
      wr_bank_q  <= wr_bank_d;
      rd_addr_q  <= rd_addr_d;
      rd_bank_q  <= rd_bank_d;
      cnt_q      <= cnt_d;
      pop_q      <= pop_d;
      swap_q     <= swap_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (play_en && rd_full) state_d = StPlay;
      end
      StPlay: begin
        if (!play_en) begin
          state_d = StIdle;
        end else if (end_of_bank && !other_full) begin
          state_d = StStall;
        end
      end
      StStall: begin
        if (!play_en) begin
          state_d = StIdle;
        end else if (rd_full) begin
          state_d = StPlay;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write-side bookkeeping
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    overrun_d = overrun_q;
    if (wr_ok) wr_addr_d = wr_addr_q + 1'b1;
    // A same-cycle write has already landed at the current address.
    if (commit_ok) begin
      wr_addr_d = '0;
      wr_bank_d = ~wr_bank_q;
    end
    if ((pipe_in_write || commit) && wr_full) overrun_d = 1'b1;
  end

  // Read-side outputs, divider and bank occupancy
  always_comb begin
    full_d     = full_q;
    rd_addr_d  = rd_addr_q;
    rd_bank_d  = rd_bank_q;
    cnt_d      = cnt_q;
    pop_d      = 1'b0;
    swap_d     = 1'b0;
    underrun_d = underrun_q;

    if (commit_ok) full_d[wr_bank_q] = 1'b1;

    case (state_q)
      StPlay: begin
        if (!play_en) begin
          // Bank stays full so it replays from word 0 on re-enable.
          rd_addr_d = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_hit ? '0 : cnt_q + 1'b1;
          if (pop_q) rd_addr_d = rd_addr_q + 1'b1;
          if (end_of_bank) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_addr_d         = '0;
            swap_d            = 1'b1;
            if (!other_full) begin
              underrun_d = 1'b1;
              cnt_d      = '0;
            end
          end
          // Never pop into a bank we are about to stall on.
          pop_d = cnt_hit && (state_d == StPlay);
        end
      end
      default: begin
        rd_addr_d = '0;
        cnt_d     = '0;
      end
    endcase
  end

  assign wr_addr  = wr_addr_q;
  assign wr_bank  = wr_bank_q;
  assign rd_addr  = rd_addr_q;
  assign rd_bank  = rd_bank_q;
  assign pop      = pop_q;
  assign swap     = swap_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;
  assign state    = state_q;

endmodule

// File: tb/tb_waveform_bank_sched.sv
// Directed bench for waveform_bank_sched with WR_ADDR_W=3 (4 read words/bank), DIV_W=4.
module tb_waveform_bank_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       pipe_in_write;
  logic       commit;
  logic       play_en;
  logic [3:0] rate_div;
  logic [2:0] wr_addr;
  logic       wr_bank;
  logic [1:0] rd_addr;
  logic       rd_bank;
  logic       pop;
  logic       swap;
  logic       underrun;
  logic       overrun;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  waveform_bank_sched #(
    .WR_ADDR_W(3),
    .DIV_W    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_in_write(pipe_in_write),
    .commit       (commit),
    .play_en      (play_en),
    .rate_div     (rate_div),
    .wr_addr      (wr_addr),
    .wr_bank      (wr_bank),
    .rd_addr      (rd_addr),
    .rd_bank      (rd_bank),
    .pop          (pop),
    .swap         (swap),
    .underrun     (underrun),
    .overrun      (overrun),
    .state        (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pipe_in_write = 1'b0; commit = 1'b0; play_en = 1'b0; rate_div = 4'd0;
    step();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
    check_eq({tag, ".wr_bank"}, 32'(wr_bank), 32'd0);
    check_eq({tag, ".rd_addr"}, 32'(rd_addr), 32'd0);
    check_eq({tag, ".rd_bank"}, 32'(rd_bank), 32'd0);
    check_eq({tag, ".pop"}, 32'(pop), 32'd0);
    check_eq({tag, ".swap"}, 32'(swap), 32'd0);
    check_eq({tag, ".underrun"}, 32'(underrun), 32'd0);
    check_eq({tag, ".overrun"}, 32'(overrun), 32'd0);
    check_eq({tag, ".state"}, 32'(state), 32'd0);
  endtask

  // n sample writes followed by a one-cycle commit
  task automatic fill_bank(input int n);
    pipe_in_write = 1'b1;
    repeat (n) step();
    pipe_in_write = 1'b0;
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  initial begin
    // ---- Reset state
    do_reset();
    check_all_zero("rst");

    // ---- Fill and play, rate_div=0, ends in underrun
    pipe_in_write = 1'b1;
    repeat (3) step();
    check_eq("fill.wr_addr3", 32'(wr_addr), 32'd3);
    repeat (5) step();
    check_eq("fill.wr_addr_wrap", 32'(wr_addr), 32'd0);
    pipe_in_write = 1'b0;
    commit = 1'b1;
    step();
    commit = 1'b0;
    check_eq("fill.wr_bank", 32'(wr_bank), 32'd1);
    check_eq("fill.wr_addr", 32'(wr_addr), 32'd0);
    play_en = 1'b1;
    step();
    check_eq("play.state", 32'(state), 32'd1);
    check_eq("play.nopop", 32'(pop), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("play.pop%0d", i), 32'(pop), 32'd1);
      check_eq($sformatf("play.addr%0d", i), 32'(rd_addr), 32'(i));
      check_eq($sformatf("play.bank%0d", i), 32'(rd_bank), 32'd0);
      check_eq($sformatf("play.swap%0d", i), 32'(swap), 32'd0);
    end
    step();
    check_eq("eob.swap", 32'(swap), 32'd1);
    check_eq("eob.pop", 32'(pop), 32'd0);
    check_eq("eob.rd_bank", 32'(rd_bank), 32'd1);
    check_eq("eob.rd_addr", 32'(rd_addr), 32'd0);
    check_eq("eob.underrun", 32'(underrun), 32'd1);
    check_eq("eob.state", 32'(state), 32'd2);
    step();
    check_eq("stall.swap", 32'(swap), 32'd0);
    check_eq("stall.state", 32'(state), 32'd2);
    check_eq("stall.pop", 32'(pop), 32'd0);

    // ---- Ping-pong: bank 1 committed while bank 0 plays
    do_reset();
    fill_bank(8);
    play_en = 1'b1;
    step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    check_eq("pp.wr_bank", 32'(wr_bank), 32'd0);
    check_eq("pp.pop0", 32'(pop), 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      check_eq($sformatf("pp.addr%0d", i), 32'(rd_addr), 32'(i));
    end
    step();
    check_eq("pp.swap", 32'(swap), 32'd1);
    check_eq("pp.pop_nogap", 32'(pop), 32'd1);
    check_eq("pp.rd_bank", 32'(rd_bank), 32'd1);
    check_eq("pp.rd_addr", 32'(rd_addr), 32'd0);
    check_eq("pp.underrun", 32'(underrun), 32'd0);
    check_eq("pp.state", 32'(state), 32'd1);
    step();
    check_eq("pp.swap_clr", 32'(swap), 32'd0);
    check_eq("pp.addr_b1", 32'(rd_addr), 32'd1);
    check_eq("pp.pop_b1", 32'(pop), 32'd1);

    // ---- Rate divider: rate_div=2 pops every 3rd cycle
    do_reset();
    fill_bank(8);
    rate_div = 4'd2;
    play_en = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq($sformatf("div.pop%0d", k), 32'(pop), (k % 3 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("div.addr%0d", k), 32'(rd_addr), 32'((k - 1) / 3));
    end

    // ---- Overrun: both banks committed, then a write and a commit
    do_reset();
    commit = 1'b1;
    step();
    step();
    commit = 1'b0;
    check_eq("ovr.wr_bank0", 32'(wr_bank), 32'd0);
    pipe_in_write = 1'b1;
    step();
    pipe_in_write = 1'b0;
    check_eq("ovr.wr_addr", 32'(wr_addr), 32'd0);
    check_eq("ovr.flag", 32'(overrun), 32'd1);
    commit = 1'b1;
    step();
    commit = 1'b0;
    check_eq("ovr.commit_bank", 32'(wr_bank), 32'd0);
    check_eq("ovr.flag_sticky", 32'(overrun), 32'd1);
    // Both banks still full: playing bank 0 must swap into bank 1 without underrun
    play_en = 1'b1;
    repeat (6) step();
    check_eq("ovr.swap", 32'(swap), 32'd1);
    check_eq("ovr.rd_bank", 32'(rd_bank), 32'd1);
    check_eq("ovr.underrun", 32'(underrun), 32'd0);
    check_eq("ovr.state", 32'(state), 32'd1);

    // ---- Stop after two pops, then restart from word 0
    do_reset();
    fill_bank(8);
    play_en = 1'b1;
    step();
    step();
    step();
    check_eq("stop.addr1", 32'(rd_addr), 32'd1);
    play_en = 1'b0;
    step();
    check_eq("stop.state", 32'(state), 32'd0);
    check_eq("stop.rd_addr", 32'(rd_addr), 32'd0);
    check_eq("stop.pop", 32'(pop), 32'd0);
    play_en = 1'b1;
    step();
    check_eq("restart.state", 32'(state), 32'd1);
    step();
    check_eq("restart.pop", 32'(pop), 32'd1);
    check_eq("restart.addr", 32'(rd_addr), 32'd0);
    check_eq("restart.bank", 32'(rd_bank), 32'd0);
    step();
    check_eq("restart.addr1", 32'(rd_addr), 32'd1);

    // ---- Reset mid-PLAY clears everything, including bank occupancy
    reset = 1'b1;
    step();
    reset = 1'b0;
    play_en = 1'b0;
    check_all_zero("midrst");
    play_en = 1'b1;
    step();
    check_eq("midrst.stay_idle", 32'(state), 32'd0);
    play_en = 1'b0;
    pipe_in_write = 1'b1;
    step();
    pipe_in_write = 1'b0;
    check_eq("midrst.write_ok", 32'(wr_addr), 32'd1);
    check_eq("midrst.no_overrun", 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
